// File: rtl/cgra_pe_mc_pkg.sv
// Shared types for the multi-context CGRA PE: opcodes, operand sources,
// the 64-bit configuration frame layout and LIF neuron defaults.
package cgra_pe_mc_pkg;

  typedef enum logic [5:0] {
    OP_NOP     = 6'd0,
    OP_ADD     = 6'd1,
    OP_SUB     = 6'd2,
    OP_MUL     = 6'd3,
    OP_MAC     = 6'd4,
    OP_CMP_GT  = 6'd10,
    OP_ACC_CLR = 6'd15,
    OP_PASS0   = 6'd16,
    OP_LIF     = 6'd18
  } op_e;

  typedef enum logic [3:0] {
    SRC_ACC = 4'd0,
    SRC_N   = 4'd1,
    SRC_E   = 4'd2,
    SRC_S   = 4'd3,
    SRC_W   = 4'd4,
    SRC_RF  = 4'd5,
    SRC_IMM = 4'd6
  } src_e;

  typedef struct packed {
    logic [22:0] rsvd;
    logic        pred_inv;
    logic [15:0] imm;
    logic        pred_en;
    logic [4:0]  route;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src0;
    logic [5:0]  op;
  } frame_t;

  localparam int ROUTE_N = 0;
  localparam int ROUTE_E = 1;
  localparam int ROUTE_S = 2;
  localparam int ROUTE_W = 3;
  localparam int ROUTE_L = 4;

  localparam int LIF_LEAK_DEF   = 10;
  localparam int LIF_REFRAC_DEF = 2;

  // A neighbour named by both sources is still only one required operand.
  function automatic logic src_needs(input logic [3:0] s0, input logic [3:0] s1,
                                     input src_e dir);
    return (s0 == dir) || (s1 == dir);
  endfunction

endpackage

// File: rtl/cgra_pe_mc_if.sv
// Mesh-side bundle of the PE: configuration bus, sequencing controls,
// neighbour operands and routed results. All valids are single-cycle qualifiers.
interface cgra_pe_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CW         = 2
);
  logic [63:0]           config_frame;
  logic                  config_valid;
  logic [CW-1:0]         config_ctx;
  logic                  run_en;
  logic [CW-1:0]         ctx_last;

  logic [DATA_WIDTH-1:0] data_in_n, data_in_e, data_in_s, data_in_w;
  logic                  valid_in_n, valid_in_e, valid_in_s, valid_in_w;

  logic [DATA_WIDTH-1:0] data_out_n, data_out_e, data_out_s, data_out_w;
  logic                  valid_out_n, valid_out_e, valid_out_s, valid_out_w;
  logic [DATA_WIDTH-1:0] data_out_local;
  logic                  valid_out_local;
  logic [CW-1:0]         ctx_ptr;
  logic                  stall;

  modport master (
    output config_frame, config_valid, config_ctx, run_en, ctx_last,
    output data_in_n, data_in_e, data_in_s, data_in_w,
    output valid_in_n, valid_in_e, valid_in_s, valid_in_w,
    input  data_out_n, data_out_e, data_out_s, data_out_w,
    input  valid_out_n, valid_out_e, valid_out_s, valid_out_w,
    input  data_out_local, valid_out_local, ctx_ptr, stall
  );

  modport slave (
    input  config_frame, config_valid, config_ctx, run_en, ctx_last,
    input  data_in_n, data_in_e, data_in_s, data_in_w,
    input  valid_in_n, valid_in_e, valid_in_s, valid_in_w,
    output data_out_n, data_out_e, data_out_s, data_out_w,
    output valid_out_n, valid_out_e, valid_out_s, valid_out_w,
    output data_out_local, valid_out_local, ctx_ptr, stall
  );
endinterface

// File: rtl/cgra_pe_mc_alu.sv
// Combinational datapath of the PE: computes the result and the next
// ACC/VMEM/REFRAC/PRED values plus write/route enables for one context.
module cgra_pe_mc_alu
  import cgra_pe_mc_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int RW            = 2,
  parameter int LIF_LEAK      = LIF_LEAK_DEF,
  parameter int REFRAC_CYCLES = LIF_REFRAC_DEF
) (
  input  logic [5:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] vmem_i,
  input  logic [RW-1:0]         refrac_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [DATA_WIDTH-1:0] vmem_o,
  output logic [RW-1:0]         refrac_o,
  output logic                  pred_we_o,
  output logic                  pred_o,
  output logic                  rf_we_o,
  output logic                  out_en_o
);

  logic [DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH+1:0] lif_sum;
  logic [DATA_WIDTH-1:0] lif_v;
  logic                  gt;

  assign prod = a_i * b_i;
  assign gt   = $signed(a_i) > $signed(b_i);

  // Two guard bits: the top one flags underflow, the next one overflow.
  assign lif_sum = {2'b00, a_i} + {2'b00, vmem_i} - (DATA_WIDTH+2)'(LIF_LEAK);

  always_comb begin
    lif_v = lif_sum[DATA_WIDTH-1:0];
    if (lif_sum[DATA_WIDTH+1]) begin
      lif_v = '0;
    end else if (lif_sum[DATA_WIDTH]) begin
      lif_v = '1;
    end
  end

  always_comb begin
    result_o  = '0;
    acc_o     = acc_i;
    vmem_o    = vmem_i;
    refrac_o  = refrac_i;
    pred_we_o = 1'b0;
    pred_o    = 1'b0;
    rf_we_o   = 1'b0;
    out_en_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = a_i + b_i;
        rf_we_o  = 1'b1;
        out_en_o = 1'b1;
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        rf_we_o  = 1'b1;
        out_en_o = 1'b1;
      end
      OP_MUL: begin
        result_o = prod;
        rf_we_o  = 1'b1;
        out_en_o = 1'b1;
      end
      OP_MAC: begin
        acc_o    = acc_i + prod;
        result_o = acc_i + prod;
        rf_we_o  = 1'b1;
        out_en_o = 1'b1;
      end
      OP_CMP_GT: begin
        result_o[0] = gt;
        pred_we_o   = 1'b1;
        pred_o      = gt;
        rf_we_o     = 1'b1;
        out_en_o    = 1'b1;
      end
      OP_ACC_CLR: begin
        acc_o    = '0;
        vmem_o   = '0;
        refrac_o = '0;
        out_en_o = 1'b1;
      end
      OP_PASS0: begin
        result_o = a_i;
        rf_we_o  = 1'b1;
        out_en_o = 1'b1;
      end
      OP_LIF: begin
        out_en_o = 1'b1;
        if (refrac_i != '0) begin
          refrac_o = refrac_i - RW'(1);
          vmem_o   = '0;
        end else if (lif_v >= b_i) begin
          result_o[0] = 1'b1;
          vmem_o      = '0;
          refrac_o    = RW'(REFRAC_CYCLES);
        end else begin
          vmem_o = lif_v;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cgra_pe_mc.sv
// Multi-context CGRA processing element: context store, cyclic sequencer with
// operand-valid stalling, predicate squash, state registers and output registers.
module cgra_pe_mc
  import cgra_pe_mc_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_CTX       = 4,
  parameter int RF_DEPTH      = 16,
  parameter int LIF_LEAK      = LIF_LEAK_DEF,
  parameter int REFRAC_CYCLES = LIF_REFRAC_DEF
) (
  input logic           clk,
  input logic           rst_n,
  cgra_pe_mc_if.slave   pe
);

  localparam int CW = $clog2(NUM_CTX);
  localparam int RW = (REFRAC_CYCLES < 1) ? 1 : $clog2(REFRAC_CYCLES + 1);

  logic [63:0]           ctx_mem_q [NUM_CTX];
  logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];
  logic [CW-1:0]         ctx_ptr_q, ctx_ptr_d, ctx_last_eff;
  logic [DATA_WIDTH-1:0] acc_q, vmem_q;
  logic [RW-1:0]         refrac_q;
  logic                  pred_q;

  logic [DATA_WIDTH-1:0] dout_n_q, dout_e_q, dout_s_q, dout_w_q, dout_l_q;
  logic                  vout_n_q, vout_e_q, vout_s_q, vout_w_q, vout_l_q;

  frame_t                frame;
  logic                  unused_rsvd;
  logic [DATA_WIDTH-1:0] imm_ext, rf_rd, op_a, op_b;
  logic                  operands_ok, fire, squash, commit, out_fire;

  logic [DATA_WIDTH-1:0] alu_result, alu_acc, alu_vmem;
  logic [RW-1:0]         alu_refrac;
  logic                  alu_pred_we, alu_pred, alu_rf_we, alu_out_en;

  function automatic logic [DATA_WIDTH-1:0] pick(
    input logic [3:0]            code,
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] n,
    input logic [DATA_WIDTH-1:0] e,
    input logic [DATA_WIDTH-1:0] s,
    input logic [DATA_WIDTH-1:0] w,
    input logic [DATA_WIDTH-1:0] rf,
    input logic [DATA_WIDTH-1:0] imm
  );
    case (code)
      SRC_ACC: return acc;
      SRC_N:   return n;
      SRC_E:   return e;
      SRC_S:   return s;
      SRC_W:   return w;
      SRC_RF:  return rf;
      SRC_IMM: return imm;
      default: return '0;
    endcase
  endfunction

  // The frame being fired is read before any same-edge config write lands.
  assign frame       = frame_t'(ctx_mem_q[ctx_ptr_q]);
  assign unused_rsvd = ^frame.rsvd;
  assign imm_ext     = DATA_WIDTH'(frame.imm);
  assign rf_rd       = rf_q[frame.dst];

  assign op_a = pick(frame.src0, acc_q, pe.data_in_n, pe.data_in_e, pe.data_in_s,
                     pe.data_in_w, rf_rd, imm_ext);
  assign op_b = pick(frame.src1, acc_q, pe.data_in_n, pe.data_in_e, pe.data_in_s,
                     pe.data_in_w, rf_rd, imm_ext);

  assign operands_ok = (!src_needs(frame.src0, frame.src1, SRC_N) || pe.valid_in_n) &&
                       (!src_needs(frame.src0, frame.src1, SRC_E) || pe.valid_in_e) &&
                       (!src_needs(frame.src0, frame.src1, SRC_S) || pe.valid_in_s) &&
                       (!src_needs(frame.src0, frame.src1, SRC_W) || pe.valid_in_w);

  assign fire     = pe.run_en && operands_ok;
  assign squash   = frame.pred_en && !(pred_q ^ frame.pred_inv);
  assign commit   = fire && !squash;
  assign out_fire = commit && alu_out_en;

  cgra_pe_mc_alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RW           (RW),
    .LIF_LEAK     (LIF_LEAK),
    .REFRAC_CYCLES(REFRAC_CYCLES)
  ) u_alu (
    .op_i     (frame.op),
    .a_i      (op_a),
    .b_i      (op_b),
    .acc_i    (acc_q),
    .vmem_i   (vmem_q),
    .refrac_i (refrac_q),
    .result_o (alu_result),
    .acc_o    (alu_acc),
    .vmem_o   (alu_vmem),
    .refrac_o (alu_refrac),
    .pred_we_o(alu_pred_we),
    .pred_o   (alu_pred),
    .rf_we_o  (alu_rf_we),
    .out_en_o (alu_out_en)
  );

  // Squashed firings and NOPs still advance the loop.
  always_comb begin
    ctx_last_eff = pe.ctx_last;
    if (pe.ctx_last > CW'(NUM_CTX - 1)) begin
      ctx_last_eff = CW'(NUM_CTX - 1);
    end
    ctx_ptr_d = ctx_ptr_q;
    if (!pe.run_en) begin
      ctx_ptr_d = '0;
    end else if (fire) begin
      if (ctx_ptr_q == ctx_last_eff || ctx_ptr_q == CW'(NUM_CTX - 1)) begin
        ctx_ptr_d = '0;
      end else begin
        ctx_ptr_d = ctx_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) ctx_mem_q[i] <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      ctx_ptr_q <= '0;
      acc_q     <= '0;
      vmem_q    <= '0;
      refrac_q  <= '0;
      pred_q    <= 1'b0;
      dout_n_q  <= '0;
      dout_e_q  <= '0;
      dout_s_q  <= '0;
      dout_w_q  <= '0;
      dout_l_q  <= '0;
      vout_n_q  <= 1'b0;
      vout_e_q  <= 1'b0;
      vout_s_q  <= 1'b0;
      vout_w_q  <= 1'b0;
      vout_l_q  <= 1'b0;
    end else begin
      if (pe.config_valid) ctx_mem_q[pe.config_ctx] <= pe.config_frame;
      ctx_ptr_q <= ctx_ptr_d;
      vout_n_q  <= out_fire && frame.route[ROUTE_N];
      vout_e_q  <= out_fire && frame.route[ROUTE_E];
      vout_s_q  <= out_fire && frame.route[ROUTE_S];
      vout_w_q  <= out_fire && frame.route[ROUTE_W];
      vout_l_q  <= out_fire && frame.route[ROUTE_L];
      if (commit) begin
        acc_q    <= alu_acc;
        vmem_q   <= alu_vmem;
        refrac_q <= alu_refrac;
        if (alu_pred_we) pred_q <= alu_pred;
        if (alu_rf_we) rf_q[frame.dst] <= alu_result;
      end
      if (out_fire && frame.route[ROUTE_N]) dout_n_q <= alu_result;
      if (out_fire && frame.route[ROUTE_E]) dout_e_q <= alu_result;
      if (out_fire && frame.route[ROUTE_S]) dout_s_q <= alu_result;
      if (out_fire && frame.route[ROUTE_W]) dout_w_q <= alu_result;
      if (out_fire && frame.route[ROUTE_L]) dout_l_q <= alu_result;
    end
  end

  assign pe.data_out_n      = dout_n_q;
  assign pe.data_out_e      = dout_e_q;
  assign pe.data_out_s      = dout_s_q;
  assign pe.data_out_w      = dout_w_q;
  assign pe.data_out_local  = dout_l_q;
  assign pe.valid_out_n     = vout_n_q;
  assign pe.valid_out_e     = vout_e_q;
  assign pe.valid_out_s     = vout_s_q;
  assign pe.valid_out_w     = vout_w_q;
  assign pe.valid_out_local = vout_l_q;
  assign pe.ctx_ptr         = ctx_ptr_q;
  assign pe.stall           = pe.run_en && !operands_ok;

endmodule
